// File: rtl/clkgen_ce72.sv
// Reset sequencer and phase-aligned clock-enable generator for the 72 MHz domain.
// Turns PLL lock into sys_reset and derives the 12/6/3/1.5 MHz enables plus the CPU enable.
module clkgen_ce72 #(
  parameter int unsigned DIV_BASE   = 6,
  parameter int unsigned RESET_HOLD = 1024
) (
  input  logic       clk72,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       cpu_stall,
  input  logic       turbo,
  output logic       sys_reset,
  output logic       ce_12,
  output logic       ce_6,
  output logic       ce_3,
  output logic       ce_1m5,
  output logic       cpu_ce,
  output logic [2:0] phase
);

  localparam int unsigned BASE_W = $clog2(DIV_BASE);
  localparam int unsigned HOLD_W = 16;
  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(DIV_BASE - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                lock_meta_q, lock_s_q;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [2:0]          phase_q, phase_d;
  logic                sys_reset_q, sys_reset_d;
  logic                ce_12_q, ce_12_d;
  logic                ce_6_q, ce_6_d;
  logic                ce_3_q, ce_3_d;
  logic                ce_1m5_q, ce_1m5_d;
  logic                turbo_q, turbo_d;
  logic                run_d;
  logic                cpu_ce_c;

  // Two-flop synchroniser for the asynchronous lock flag
  always_ff @(posedge clk72) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge clk72) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      hold_cnt_q  <= '0;
      base_q      <= '0;
      phase_q     <= '0;
      sys_reset_q <= 1'b1;
      ce_12_q     <= 1'b0;
      ce_6_q      <= 1'b0;
      ce_3_q      <= 1'b0;
      ce_1m5_q    <= 1'b0;
      turbo_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      base_q      <= base_d;
      phase_q     <= phase_d;
      sys_reset_q <= sys_reset_d;
      ce_12_q     <= ce_12_d;
      ce_6_q      <= ce_6_d;
      ce_3_q      <= ce_3_d;
      ce_1m5_q    <= ce_1m5_d;
      turbo_q     <= turbo_d;
    end
  end

  // Next-state: lock qualification FSM, then enables computed from next-cycle counter values
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    base_d     = '0;
    phase_d    = '0;

    case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      RUN: begin
        if (!lock_s_q) state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase

    run_d       = (state_d == RUN);
    sys_reset_d = !run_d;

    // Counters start from zero on the first RUN cycle and clear whenever RUN is left
    if (run_d && (state_q == RUN)) begin
      base_d = (base_q == BASE_LAST) ? '0 : base_q + BASE_W'(1);
    end
    if (run_d) begin
      phase_d = ce_12_q ? phase_q + 3'd1 : phase_q;
    end

    ce_12_d  = run_d && (base_d == BASE_LAST);
    ce_6_d   = ce_12_d && phase_d[0];
    ce_3_d   = ce_12_d && (phase_d[1:0] == 2'b11);
    ce_1m5_d = ce_12_d && (phase_d == 3'd7);
    turbo_d  = ce_1m5_q ? turbo : turbo_q;
  end

  // Stall must gate in the same cycle, so the CPU enable is combinational from registered enables
  assign cpu_ce_c = (turbo_q ? ce_6_q : ce_3_q) & ~cpu_stall;

  assign sys_reset = sys_reset_q;
  assign ce_12     = ce_12_q;
  assign ce_6      = ce_6_q;
  assign ce_3      = ce_3_q;
  assign ce_1m5    = ce_1m5_q;
  assign cpu_ce    = cpu_ce_c;
  assign phase     = phase_q;

endmodule

// File: tb/tb_clkgen_ce72.sv
// Directed bench for clkgen_ce72: power-up, enable cadence, stall/turbo gating, lock loss and bounce.
module tb_clkgen_ce72;

  localparam int RH = 1024;

  logic       clk72;
  logic       reset;
  logic       pll_lock;
  logic       cpu_stall;
  logic       turbo;
  logic       sys_reset;
  logic       ce_12, ce_6, ce_3, ce_1m5, cpu_ce;
  logic [2:0] phase;

  int vectors;
  int miscompares;
  bit exp_tq;

  clkgen_ce72 #(.DIV_BASE(6), .RESET_HOLD(RH)) dut (
    .clk72     (clk72),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .cpu_stall (cpu_stall),
    .turbo     (turbo),
    .sys_reset (sys_reset),
    .ce_12     (ce_12),
    .ce_6      (ce_6),
    .ce_3      (ce_3),
    .ce_1m5    (ce_1m5),
    .cpu_ce    (cpu_ce),
    .phase     (phase)
  );

  initial clk72 = 1'b0;
  always #5 clk72 = ~clk72;

  task automatic tick();
    @(posedge clk72);
    #1;
  endtask

  task automatic chk(input string tag, input int t, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // All outputs in the reset/idle condition
  task automatic chk_idle(input string tag, input int t);
    chk({tag, "_sysrst"}, t, {3'b0, sys_reset}, 4'd1);
    chk({tag, "_ces"}, t, {ce_12, ce_6, ce_3, ce_1m5}, 4'd0);
    chk({tag, "_cpuce"}, t, {3'b0, cpu_ce}, 4'd0);
    chk({tag, "_phase"}, t, {1'b0, phase}, 4'd0);
  endtask

  // From lock rising: sys_reset holds for RH+2 edges, then releases (caller is then at T0)
  task automatic acquire(input string tag);
    for (int i = 0; i < RH + 2; i++) begin
      tick();
      chk({tag, "_hold_sysrst"}, i, {3'b0, sys_reset}, 4'd1);
      chk({tag, "_hold_ce12"}, i, {3'b0, ce_12}, 4'd0);
    end
    tick();
    chk({tag, "_t0_sysrst"}, 0, {3'b0, sys_reset}, 4'd0);
  endtask

  // Checks ncyc cycles starting at T0 (caller already positioned at T0)
  task automatic run_cadence(input string tag, input int ncyc, input int stall_lo,
                             input int stall_hi, input int turbo_at);
    bit e12, e6, e3, e15, ecpu, stl;
    int ph;
    for (int t = 0; t < ncyc; t++) begin
      if (t > 0) tick();
      stl       = (t >= stall_lo) && (t <= stall_hi);
      cpu_stall = stl;
      turbo     = (t >= turbo_at);
      #1;
      e12  = (t % 6) == 5;
      ph   = (t / 6) % 8;
      e6   = e12 && (ph % 2 == 1);
      e3   = e12 && (ph % 4 == 3);
      e15  = e12 && (ph == 7);
      ecpu = (exp_tq ? e6 : e3) && !stl;
      chk({tag, "_sysrst"}, t, {3'b0, sys_reset}, 4'd0);
      chk({tag, "_ce12"}, t, {3'b0, ce_12}, {3'b0, e12});
      chk({tag, "_ce6"}, t, {3'b0, ce_6}, {3'b0, e6});
      chk({tag, "_ce3"}, t, {3'b0, ce_3}, {3'b0, e3});
      chk({tag, "_ce1m5"}, t, {3'b0, ce_1m5}, {3'b0, e15});
      chk({tag, "_phase"}, t, {1'b0, phase}, 4'(ph));
      chk({tag, "_cpuce"}, t, {3'b0, cpu_ce}, {3'b0, ecpu});
      if (e15) exp_tq = turbo;
    end
    cpu_stall = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_tq      = 1'b0;
    reset       = 1'b1;
    pll_lock    = 1'b0;
    cpu_stall   = 1'b0;
    turbo       = 1'b0;

    // Power-up reset for 4 cycles
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_idle("reset", i);
    end
    reset = 1'b0;
    for (int i = 5; i <= 9; i++) begin
      tick();
      chk_idle("prelock", i);
    end

    // Lock rises at cycle 10; sys_reset falls 2+RH cycles later
    pll_lock = 1'b1;
    acquire("pwrup");

    // Cadence with stall across the T0+23 tick and turbo asserted at T0+30
    run_cadence("run1", 200, 21, 25, 30);

    // Lock loss in RUN: reset reasserts on the third edge after the drop
    pll_lock = 1'b0;
    tick();
    tick();
    tick();
    chk_idle("lossy", 3);
    for (int i = 4; i < 10; i++) begin
      tick();
      chk_idle("lost", i);
    end

    // Lock bounce: 500 high, 3 low, then a full fresh hold is required
    pll_lock = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      chk({"bounce_sysrst"}, i, {3'b0, sys_reset}, 4'd1);
    end
    pll_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("bounce_low", i);
    end
    pll_lock = 1'b1;
    acquire("reacq");

    // Fresh T0 with turbo held high: CPU enable tracks ce_6
    run_cadence("run2", 100, -1, -1, 0);

    // Reset concurrent with a lock drop: reset wins on the next edge
    reset    = 1'b1;
    pll_lock = 1'b0;
    tick();
    chk_idle("rst_run", 1);
    tick();
    chk_idle("rst_run", 2);
    reset = 1'b0;
    tick();
    chk_idle("post_rst", 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
